score_sequencer: RTL and testbench

- Game-level controller that sequences the 8-bit score counter of the slug game.
- Decides when the score is cleared (new game) and when it increments (obstacle passed), and freezes it on collision.
- Runs the death-flash interval and tracks the high score.
- Sits between the play-field logic (frame tick, pass/hit detect) and the score counter, whose Inc/r inputs it drives.

---
 rtl/score_sequencer.sv | 164 ++++++++++++++++
 tb/tb_score_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_sequencer.sv
// rtl/score_sequencer.sv - slug game score/life-cycle sequencer; optional hi-score register under SCORE_HI_TRACK_EN
module score_sequencer #(
    parameter int DYING_FRAMES = 120,
    parameter int FLASH_HALF   = 8
) (
    input  logic       clk,
    input  logic       r,
    input  logic       frame,
    input  logic       go,
    input  logic       pass,
    input  logic       hit,
    input  logic [7:0] score,
    output logic       score_inc,
    output logic       score_clr,
    output logic [7:0] hi_score,
    output logic       playing,
    output logic       flash,
    output logic       over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PLAY  = 2'b01,
        DYING = 2'b10,
        OVER  = 2'b11
    } state_t;

    localparam int FW  = $clog2(DYING_FRAMES + 1);
    localparam int FHW = $clog2(FLASH_HALF + 1);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(DYING_FRAMES - 1);
    localparam logic [FHW-1:0] FLASH_LAST = FHW'(FLASH_HALF - 1);

    state_t         state_q, state_d;
    logic           go_q, go_d;
    logic [FW-1:0]  frame_cnt_q, frame_cnt_d;
    logic [FHW-1:0] flash_cnt_q, flash_cnt_d;
    logic           flash_q, flash_d;
    logic           score_inc_q, score_inc_d;
    logic           score_clr_q, score_clr_d;
    logic           playing_q, playing_d;
    logic           over_q, over_d;
    logic           go_rise;
    logic           hi_load;

    assign go_rise = go & ~go_q;

    // Next-state and next-output decode for the game life cycle
    always_comb begin
        state_d     = state_q;
        go_d        = go;
        frame_cnt_d = frame_cnt_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = flash_q;
        score_inc_d = 1'b0;
        score_clr_d = 1'b0;
        hi_load     = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_rise) begin
                    state_d     = PLAY;
                    score_clr_d = 1'b1;
                end
            end
            PLAY: begin
                // Collision outranks a simultaneous obstacle pass
                if (hit) begin
                    state_d     = DYING;
                    frame_cnt_d = '0;
                    flash_cnt_d = '0;
                    flash_d     = 1'b1;
                end else if (pass && (score != 8'hFF)) begin
                    score_inc_d = 1'b1;
                end
            end
            DYING: begin
                if (frame) begin
                    if (frame_cnt_q == FRAME_LAST) begin
                        state_d = OVER;
                        flash_d = 1'b0;
                        hi_load = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FW'(1);
                        if (flash_cnt_q == FLASH_LAST) begin
                            flash_cnt_d = '0;
                            flash_d     = ~flash_q;
                        end else begin
                            flash_cnt_d = flash_cnt_q + FHW'(1);
                        end
                    end
                end
            end
            OVER: begin
                if (go_rise) begin
                    state_d     = PLAY;
                    score_clr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        playing_d = (state_d == PLAY);
        over_d    = (state_d == OVER);
    end

    // Register state, counters and all outputs; reset overrides everything
    always_ff @(posedge clk) begin
        if (r) begin
            state_q     <= IDLE;
            go_q        <= 1'b1;
            frame_cnt_q <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
            score_inc_q <= 1'b0;
            score_clr_q <= 1'b0;
            playing_q   <= 1'b0;
            over_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            go_q        <= go_d;
            frame_cnt_q <= frame_cnt_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
            score_inc_q <= score_inc_d;
            score_clr_q <= score_clr_d;
            playing_q   <= playing_d;
            over_q      <= over_d;
        end
    end

`ifdef SCORE_HI_TRACK_EN
    logic [7:0] hi_score_q, hi_score_d;

    // Capture the finished game's score when it beats the best so far
    always_comb begin
        hi_score_d = hi_score_q;
        if (hi_load && (score > hi_score_q)) begin
            hi_score_d = score;
        end
    end

    // Best-score register, cleared only by reset
    always_ff @(posedge clk) begin
        if (r) begin
            hi_score_q <= 8'h00;
        end else begin
            hi_score_q <= hi_score_d;
        end
    end

    assign hi_score = hi_score_q;
`else
    logic unused_hi_load;
    assign unused_hi_load = hi_load;
    assign hi_score       = 8'h00;
`endif

    assign score_inc = score_inc_q;
    assign score_clr = score_clr_q;
    assign playing   = playing_q;
    assign flash     = flash_q;
    assign over      = over_q;
    assign state     = state_q;

endmodule

// File: tb/tb_score_sequencer.sv
// tb/tb_score_sequencer.sv - self-checking bench for score_sequencer
module tb_score_sequencer;

    localparam int DYING_FRAMES = 120;
    localparam int FLASH_HALF   = 8;
`ifdef SCORE_HI_TRACK_EN
    localparam int HI_ON = 1;
`else
    localparam int HI_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       r, frame, go, pass, hit;
    logic [7:0] score;
    logic       score_inc, score_clr, playing, flash, over;
    logic [7:0] hi_score;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    logic       preload_en;
    logic [7:0] preload_val;
    logic [7:0] score_cnt;

    always #5 clk = ~clk;

    score_sequencer #(.DYING_FRAMES(DYING_FRAMES), .FLASH_HALF(FLASH_HALF)) dut (
        .clk(clk), .r(r), .frame(frame), .go(go), .pass(pass), .hit(hit),
        .score(score), .score_inc(score_inc), .score_clr(score_clr),
        .hi_score(hi_score), .playing(playing), .flash(flash), .over(over),
        .state(state)
    );

    // Score counter the sequencer drives
    always @(posedge clk) begin
        if (preload_en)      score_cnt <= preload_val;
        else if (score_clr)  score_cnt <= 8'd0;
        else if (score_inc)  score_cnt <= score_cnt + 8'd1;
    end
    assign score = score_cnt;

    // Game-rule model: mode 0 idle, 1 play, 2 dying, 3 over
    int m_mode = 0;
    int m_frames = 0;
    int m_hi = 0;
    bit m_inc = 0, m_clr = 0, m_gprev = 1;
    always @(posedge clk) begin
        bit rise;
        if (r) begin
            m_mode = 0; m_frames = 0; m_hi = 0;
            m_inc = 0; m_clr = 0; m_gprev = 1;
        end else begin
            rise = go && !m_gprev;
            m_gprev = go;
            m_inc = 0;
            m_clr = 0;
            case (m_mode)
                0: if (rise) begin m_mode = 1; m_clr = 1; end
                1: begin
                    if (hit) begin
                        m_mode = 2;
                        m_frames = 0;
                    end else if (pass && int'(score) < 255) begin
                        m_inc = 1;
                    end
                end
                2: if (frame) begin
                    m_frames++;
                    if (m_frames == DYING_FRAMES) begin
                        m_mode = 3;
                        if (HI_ON == 1 && int'(score) > m_hi) m_hi = int'(score);
                    end
                end
                default: if (rise) begin m_mode = 1; m_clr = 1; end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cmp_model();
        int exp_flash;
        exp_flash = (m_mode == 2) ? (((m_frames / FLASH_HALF) % 2 == 0) ? 1 : 0) : 0;
        chk("m_state", 32'(state), 32'(m_mode));
        chk("m_score_inc", 32'(score_inc), 32'(m_inc));
        chk("m_score_clr", 32'(score_clr), 32'(m_clr));
        chk("m_playing", 32'(playing), (m_mode == 1) ? 1 : 0);
        chk("m_over", 32'(over), (m_mode == 3) ? 1 : 0);
        chk("m_flash", 32'(flash), 32'(exp_flash));
        chk("m_hi_score", 32'(hi_score), 32'(m_hi));
        chk("m_inc_clr_excl", 32'(score_inc & score_clr), 0);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
    endtask

    task automatic press_go();
        go = 1'b1;
        tick();
        chk("restart_clr", 32'(score_clr), 1);
        chk("restart_state", 32'(state), 1);
        go = 1'b0;
        tick();
    endtask

    task automatic preload(input logic [7:0] v);
        preload_en = 1'b1;
        preload_val = v;
        tick();
        preload_en = 1'b0;
    endtask

    task automatic kill();
        hit = 1'b1;
        tick();
        hit = 1'b0;
        chk("kill_state", 32'(state), 2);
        chk("kill_flash", 32'(flash), 1);
    endtask

    task automatic run_dying();
        for (int i = 0; i < DYING_FRAMES * 4; i++) begin
            frame = (i % 4 == 3);
            tick();
            if (i == 31) chk("flash_after_8", 32'(flash), 0);
            if (i == 63) chk("flash_after_16", 32'(flash), 1);
            if (i == DYING_FRAMES * 4 - 2) chk("still_dying_119", 32'(state), 2);
        end
        frame = 1'b0;
        chk("over_state_120", 32'(state), 3);
        chk("over_flag", 32'(over), 1);
        chk("over_flash", 32'(flash), 0);
    endtask

    initial begin
        r = 1'b1; go = 1'b1; frame = 1'b0; pass = 1'b0; hit = 1'b0;
        preload_en = 1'b1; preload_val = 8'd0;
        tick();
        tick();
        preload_en = 1'b0;
        chk("reset_state", 32'(state), 0);
        chk("reset_hi", 32'(hi_score), 0);
        r = 1'b0;

        repeat (10) tick();
        chk("go_held_state", 32'(state), 0);
        go = 1'b0;
        tick();
        tick();
        go = 1'b1;
        tick();
        chk("start_clr", 32'(score_clr), 1);
        chk("start_state", 32'(state), 1);
        tick();
        chk("start_clr_once", 32'(score_clr), 0);
        go = 1'b0;

        for (int k = 0; k < 5; k++) begin
            pass = 1'b1;
            tick();
            pass = 1'b0;
            chk("inc_latency", 32'(score_inc), 1);
            tick();
            tick();
        end
        tick();
        chk("five_passes", 32'(score_cnt), 5);

        // game 1 ends at 3
        preload(8'd3);
        pass = 1'b1;
        hit = 1'b1;
        tick();
        pass = 1'b0;
        hit = 1'b0;
        chk("hit_wins_inc", 32'(score_inc), 0);
        chk("hit_state", 32'(state), 2);
        run_dying();
        chk("hi_game1", 32'(hi_score), (HI_ON == 1) ? 3 : 0);

        // game 2 ends at 7
        press_go();
        preload(8'd7);
        kill();
        run_dying();
        chk("hi_game2", 32'(hi_score), (HI_ON == 1) ? 7 : 0);

        // game 3 ends at 2
        press_go();
        preload(8'd2);
        kill();
        run_dying();
        chk("hi_game3", 32'(hi_score), (HI_ON == 1) ? 7 : 0);

        // game 4: saturation, then reset mid-death
        press_go();
        preload(8'd255);
        pass = 1'b1;
        tick();
        pass = 1'b0;
        chk("sat_no_inc", 32'(score_inc), 0);
        tick();
        kill();
        for (int i = 0; i < 20; i++) begin
            frame = (i % 4 == 3);
            tick();
        end
        frame = 1'b0;
        r = 1'b1;
        tick();
        r = 1'b0;
        chk("rst_state", 32'(state), 0);
        chk("rst_flash", 32'(flash), 0);
        chk("rst_hi", 32'(hi_score), 0);
        chk("rst_inc", 32'(score_inc), 0);
        chk("rst_clr", 32'(score_clr), 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
